// File: rtl/lock_supervisor_if.sv
// Bus between the lock supervisor and the lock core: forwarded press pulses,
// sequence clear, and the core's unlock indication.
interface lock_supervisor_if;
  logic core_btn_0;
  logic core_btn_1;
  logic core_clear;
  logic core_unlock;

  modport master (
    output core_btn_0,
    output core_btn_1,
    output core_clear,
    input  core_unlock
  );

  modport slave (
    input  core_btn_0,
    input  core_btn_1,
    input  core_clear,
    output core_unlock
  );
endinterface

// File: rtl/lock_supervisor.sv
// Lock supervisor: edge-detects raw buttons, frames presses into attempts for the
// lock core, counts failures, enforces lockout and auto-relocks after a hold time.
module lock_supervisor #(
  parameter int unsigned CODE_LEN       = 4,
  parameter int unsigned CORE_LAT       = 2,
  parameter int unsigned MAX_FAIL       = 3,
  parameter int unsigned LOCKOUT_CYCLES = 100,
  parameter int unsigned HOLD_CYCLES    = 50,
  parameter int unsigned IDLE_TIMEOUT   = 200
) (
  input  logic                              clk,
  input  logic                              btn_reset,
  input  logic                              btn_0,
  input  logic                              btn_1,
  lock_supervisor_if.master                 core,
  output logic                              unlock,
  output logic                              locked_out,
  output logic [$clog2(MAX_FAIL+1)-1:0]     fail_count
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ENTRY   = 3'd1;
  localparam logic [2:0] S_CHECK   = 3'd2;
  localparam logic [2:0] S_OPEN    = 3'd3;
  localparam logic [2:0] S_LOCKOUT = 3'd4;
  localparam logic [2:0] S_CLEAR   = 3'd5;

  localparam int unsigned MAX_A = (CORE_LAT > HOLD_CYCLES) ? CORE_LAT : HOLD_CYCLES;
  localparam int unsigned MAX_B = (LOCKOUT_CYCLES > IDLE_TIMEOUT) ? LOCKOUT_CYCLES : IDLE_TIMEOUT;
  localparam int unsigned T_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int unsigned TW    = $clog2(T_MAX + 1);
  localparam int unsigned PW    = $clog2(CODE_LEN + 1);
  localparam int unsigned FW    = $clog2(MAX_FAIL + 1);

  localparam logic [TW-1:0] LAT_T  = TW'(CORE_LAT);
  localparam logic [TW-1:0] HOLD_T = TW'(HOLD_CYCLES);
  localparam logic [TW-1:0] LOCK_T = TW'(LOCKOUT_CYCLES);
  localparam logic [TW-1:0] IDLE_T = TW'(IDLE_TIMEOUT);
  localparam logic [PW-1:0] LAST_CNT = PW'(CODE_LEN - 1);
  localparam logic [FW-1:0] FAIL_MAX = FW'(MAX_FAIL);

  logic [2:0]    state;
  logic [TW-1:0] timer;
  logic [PW-1:0] press_cnt;
  logic          bad;
  logic          samp_0, samp_1, prev_0, prev_1;
  logic          rise_0, rise_1, press, both;
  logic          timer_done;
  logic [FW-1:0] fail_inc;

  // Buttons are sampled once, then compared against the previous sample.
  always_comb begin
    rise_0     = samp_0 & ~prev_0;
    rise_1     = samp_1 & ~prev_1;
    press      = rise_0 | rise_1;
    both       = rise_0 & rise_1;
    timer_done = (timer <= TW'(1));
    fail_inc   = (fail_count >= FAIL_MAX) ? FAIL_MAX : fail_count + 1'b1;
  end

  always_ff @(posedge clk or negedge btn_reset) begin
    if (!btn_reset) begin
      state           <= S_IDLE;
      timer           <= '0;
      press_cnt       <= '0;
      bad             <= 1'b0;
      samp_0          <= 1'b0;
      samp_1          <= 1'b0;
      prev_0          <= 1'b0;
      prev_1          <= 1'b0;
      core.core_btn_0 <= 1'b0;
      core.core_btn_1 <= 1'b0;
      core.core_clear <= 1'b0;
      unlock          <= 1'b0;
      locked_out      <= 1'b0;
      fail_count      <= '0;
    end else begin
      samp_0          <= btn_0;
      samp_1          <= btn_1;
      prev_0          <= samp_0;
      prev_1          <= samp_1;
      core.core_btn_0 <= 1'b0;
      core.core_btn_1 <= 1'b0;
      core.core_clear <= 1'b0;

      case (state)
        S_IDLE: begin
          if (press) begin
            core.core_btn_0 <= rise_0 & ~both;
            core.core_btn_1 <= rise_1 & ~both;
            press_cnt       <= PW'(1);
            bad             <= both;
            if (CODE_LEN == 1) begin
              state <= S_CHECK;
              timer <= LAT_T;
            end else begin
              state <= S_ENTRY;
              timer <= IDLE_T;
            end
          end
        end

        S_ENTRY: begin
          if (press) begin
            core.core_btn_0 <= rise_0 & ~both;
            core.core_btn_1 <= rise_1 & ~both;
            press_cnt       <= press_cnt + 1'b1;
            if (both) bad <= 1'b1;
            if (press_cnt == LAST_CNT) begin
              state <= S_CHECK;
              timer <= LAT_T;
            end else begin
              timer <= IDLE_T;
            end
          end else if (timer_done) begin
            // Abandoned partial attempt: discard without counting a failure.
            state           <= S_CLEAR;
            core.core_clear <= 1'b1;
          end else begin
            timer <= timer - 1'b1;
          end
        end

        S_CHECK: begin
          if (core.core_unlock && !bad) begin
            state      <= S_OPEN;
            unlock     <= 1'b1;
            timer      <= HOLD_T;
            fail_count <= '0;
          end else if (timer_done) begin
            fail_count <= fail_inc;
            if (fail_inc == FAIL_MAX) begin
              state      <= S_LOCKOUT;
              locked_out <= 1'b1;
              timer      <= LOCK_T;
            end else begin
              state           <= S_CLEAR;
              core.core_clear <= 1'b1;
            end
          end else begin
            timer <= timer - 1'b1;
          end
        end

        S_OPEN: begin
          if (timer_done) begin
            state           <= S_CLEAR;
            unlock          <= 1'b0;
            core.core_clear <= 1'b1;
          end else begin
            timer <= timer - 1'b1;
          end
        end

        S_LOCKOUT: begin
          if (timer_done) begin
            state           <= S_CLEAR;
            locked_out      <= 1'b0;
            fail_count      <= '0;
            core.core_clear <= 1'b1;
          end else begin
            timer <= timer - 1'b1;
          end
        end

        S_CLEAR: begin
          state     <= S_IDLE;
          press_cnt <= '0;
          bad       <= 1'b0;
          timer     <= '0;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/lock_supervisor.md
# lock_supervisor

Controller that sequences the lock core (the `lock_top` button/unlock datapath): edge-detects raw buttons and forwards each press as a one-cycle pulse. It frames presses into fixed-length attempts, clears the core between attempts, and counts failed attempts. It enforces a lockout after too many failures and auto-relocks after a hold time. It sits between the physical buttons and the lock core; the core's `btn_0`/`btn_1` inputs are driven only by this block.

## Interface
- `CODE_LEN`, 4: presses per attempt (≥1)
- `CORE_LAT`, 2: cycles to wait for `core_unlock` after last forwarded press (≥1)
- `MAX_FAIL`, 3: consecutive failures that trigger lockout (≥1)
- `LOCKOUT_CYCLES`, 100: lockout duration
- `HOLD_CYCLES`, 50: unlock hold duration
- `IDLE_TIMEOUT`, 200: cycles without a press that abandon a partial attempt

- `clk`  in  1  system clock, all logic on rising edge
- `btn_reset`  in  1  asynchronous, active-low reset
- `btn_0`  in  1  raw button 0 level (may be held many cycles)
- `btn_1`  in  1  raw button 1 level
- `core_unlock`  in  1  unlock indication from lock core
- `core_btn_0`  out  1  one-cycle press pulse to core
- `core_btn_1`  out  1  one-cycle press pulse to core
- `core_clear`  out  1  one-cycle pulse: core discards its sequence
- `unlock`  out  1  lock open
- `locked_out`  out  1  lockout active, presses ignored
- `fail_count`  out  $clog2(MAX_FAIL+1)  consecutive failed attempts

## Operation
- Edge detect: registered previous levels (reset 0). A press is a sample of 1 with a previous sample of 0. Held buttons count once.
- Simultaneous rising of both buttons counts as one press. It is not forwarded and sets a `bad` flag that forces failure of the current attempt.
- States: IDLE, ENTRY, CHECK, OPEN, LOCKOUT, CLEAR.
- IDLE: press → forward, `press_cnt`=1, ENTRY (CHECK directly if `CODE_LEN`=1).
- ENTRY:
  - Each press is forwarded and increments `press_cnt`.
  - The press making `press_cnt`=`CODE_LEN` → CHECK.
  - `IDLE_TIMEOUT` cycles with no press → CLEAR. Not a failure; `fail_count` unchanged.
  - `core_unlock` is ignored in ENTRY.
- CHECK:
  - Lasts `CORE_LAT` cycles; presses are dropped.
  - `core_unlock`=1 in any CHECK cycle with `bad`=0 → OPEN, `fail_count`←0.
  - Otherwise at the end of CHECK, `fail_count`+1. If the new value equals `MAX_FAIL` → LOCKOUT, else CLEAR.
- OPEN: `unlock`=1 for `HOLD_CYCLES` cycles; presses dropped. Then → CLEAR.
- LOCKOUT: `locked_out`=1 for `LOCKOUT_CYCLES` cycles; presses dropped. Then `fail_count`←0 → CLEAR.
- CLEAR: `core_clear`=1 for exactly one cycle; `press_cnt`, `bad` and the timer are zeroed. Then → IDLE.
- Dropped presses still update the edge-detect history, so a button held across a state change does not produce a press later.
- Timers are `$clog2(max+1)` wide; they load on state entry and never wrap.
- `fail_count` saturates at `MAX_FAIL`.

## Timing
- Reset (asynchronous assert, synchronous release): state IDLE; all counters 0; `core_btn_0`, `core_btn_1`, `core_clear`, `unlock`, `locked_out` = 0; `fail_count`=0. No `core_clear` pulse after reset release.
- Reset asserted mid-attempt, mid-OPEN or mid-LOCKOUT: outputs drop immediately; all progress is lost.
- All outputs are registered.
- Press latency: a press sampled at edge k gives `core_btn_x`=1 from edge k+1 to edge k+2.
- CHECK timing: entered at the same edge k+1 that raises the final pulse. It occupies the `CORE_LAT` cycles starting at k+1. `core_unlock` is sampled at edges k+2 … k+1+`CORE_LAT`.
- `unlock` rises at the edge after a successful `core_unlock` sample. It stays high exactly `HOLD_CYCLES` cycles.
- `locked_out` rises at the edge ending CHECK. It stays high exactly `LOCKOUT_CYCLES` cycles.
- `core_clear` rises at the edge that `unlock`/`locked_out` falls (or that CHECK/ENTRY exits). IDLE is reached one cycle later.
- A press arriving in the CLEAR cycle is dropped.

## Test plan
- Reset then correct 4-press code (core model asserts `core_unlock` 1 cycle after 4th pulse):
  - 4 single-cycle `core_btn` pulses, each 1 cycle after its press.
  - `unlock`=1 for 50 cycles.
  - One `core_clear` pulse, then IDLE.
- 3 wrong 4-press attempts:
  - `fail_count` 1, 2, then `locked_out`=1 for 100 cycles.
  - Presses during lockout produce no `core_btn` pulse.
  - Afterwards `fail_count`=0.
- Button held 30 cycles → exactly one `core_btn` pulse.
- Both buttons rise together as 4th press while the core model asserts `core_unlock` → no OPEN; `fail_count`=1; `core_clear` pulse.
- 2 presses then 200 idle cycles → `core_clear` pulse; `fail_count` unchanged.
- `btn_reset` asserted during OPEN and during LOCKOUT:
  - `unlock`/`locked_out` drop immediately.
  - `fail_count`=0; no `core_clear` on release.
